// File: rtl/matmul_tile_sequencer_if.sv
// matmul_tile_sequencer_if: host access, run control and core stream signals of the tile sequencer
interface matmul_tile_sequencer_if #(
    parameter int DWIDTH = 8,
    parameter int N      = 8,
    parameter int AWIDTH = 7
);
    logic                  host_we;
    logic                  host_re;
    logic [1:0]            host_sel;
    logic [AWIDTH-1:0]     host_addr;
    logic [N*DWIDTH-1:0]   host_wdata;
    logic [N*DWIDTH-1:0]   host_rdata;
    logic                  host_rvalid;
    logic                  start;
    logic [AWIDTH-1:0]     tile_base;
    logic                  accumulate;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic                  core_start;
    logic                  core_a_valid;
    logic [N*DWIDTH-1:0]   core_a_data;
    logic [N*DWIDTH-1:0]   core_b_data;
    logic                  core_c_valid;
    logic [N*DWIDTH-1:0]   core_c_data;
    modport master (
        input  host_we, host_re, host_sel, host_addr, host_wdata, start, tile_base, accumulate,
               core_c_valid, core_c_data,
        output host_rdata, host_rvalid, busy, done, err, core_start, core_a_valid, core_a_data, core_b_data
    );
    modport slave (
        output host_we, host_re, host_sel, host_addr, host_wdata, start, tile_base, accumulate,
               core_c_valid, core_c_data,
        input  host_rdata, host_rvalid, busy, done, err, core_start, core_a_valid, core_a_data, core_b_data
    );
endinterface

// File: rtl/matmul_tile_sequencer.sv
// matmul_tile_sequencer: A/B/C tile banks, row streaming into an NxN core and C write-back (overwrite or accumulate)
module matmul_tile_sequencer #(
    parameter int DWIDTH = 8,
    parameter int N      = 8,
    parameter int AWIDTH = 7
) (
    input logic clk,
    input logic resetn,
    matmul_tile_sequencer_if.master bus_io
);
    localparam int W     = N * DWIDTH;
    localparam int DEPTH = 2 ** AWIDTH;
    localparam int RW    = $clog2(N);
    localparam int PW    = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;
    state_t state_q, state_d;
    logic [AWIDTH-1:0] base_q, base_d, eng_addr, addr;
    logic acc_q, acc_d, phase_q, phase_d, done_d;
    logic [RW-1:0] row_q, row_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [W-1:0] buf_q [N];
    logic [W-1:0] mem_a [DEPTH];
    logic [W-1:0] mem_b [DEPTH];
    logic [W-1:0] mem_c [DEPTH];
    logic [W-1:0] a_q, b_q, rdata_q, c_rd_q, sum, c_wdata;
    logic a_valid_q, start_q, rvalid_q, done_q, err_q;
    logic busy, fetch, host_ok, host_wr, host_rd, cap, full, last, drain_wr;
    assign busy     = state_q != IDLE;
    assign fetch    = state_q == FETCH;
    assign eng_addr = base_q + AWIDTH'(row_q);
    assign addr     = busy ? eng_addr : bus_io.host_addr;
    assign host_ok  = !busy && (bus_io.host_we ^ bus_io.host_re) && bus_io.host_sel != 2'd3;
    assign host_wr  = host_ok && bus_io.host_we;
    assign host_rd  = host_ok && bus_io.host_re;
    assign cap      = bus_io.core_c_valid && (fetch || state_q == WAIT) && ptr_q != PW'(N);
    // count the row arriving this cycle so DRAIN follows the N-th valid directly
    assign full     = ptr_q == PW'(N) || (cap && ptr_q == PW'(N - 1));
    assign last     = row_q == RW'(N - 1);
    assign drain_wr = state_q == DRAIN && (!acc_q || phase_q);
    assign c_wdata  = busy ? (acc_q ? sum : buf_q[row_q]) : bus_io.host_wdata;
    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++)
            sum[k*DWIDTH +: DWIDTH] = buf_q[row_q][k*DWIDTH +: DWIDTH] + c_rd_q[k*DWIDTH +: DWIDTH];
    end
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        acc_d   = acc_q;
        row_d   = row_q;
        phase_d = phase_q;
        ptr_d   = cap ? ptr_q + 1'b1 : ptr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus_io.start) begin
                state_d = FETCH;
                base_d  = bus_io.tile_base;
                acc_d   = bus_io.accumulate;
                row_d   = '0;
                ptr_d   = '0;
                phase_d = 1'b0;
            end
            FETCH: begin
                row_d = last ? '0 : row_q + 1'b1;
                if (last) state_d = full ? DRAIN : WAIT;
            end
            WAIT: if (full) state_d = DRAIN;
            DRAIN: begin
                phase_d = acc_q && !phase_q;
                if (drain_wr) begin
                    row_d   = last ? '0 : row_q + 1'b1;
                    state_d = last ? IDLE : DRAIN;
                    done_d  = last;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            base_q    <= '0;
            acc_q     <= 1'b0;
            phase_q   <= 1'b0;
            row_q     <= '0;
            ptr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rdata_q   <= '0;
            c_rd_q    <= '0;
            a_valid_q <= 1'b0;
            start_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            phase_q   <= phase_d;
            row_q     <= row_d;
            ptr_q     <= ptr_d;
            a_valid_q <= fetch;
            start_q   <= fetch && row_q == '0;
            rvalid_q  <= host_rd;
            done_q    <= done_d;
            err_q     <= (bus_io.host_we || bus_io.host_re) && !host_ok;
            if (fetch) begin
                a_q <= mem_a[addr];
                b_q <= mem_b[addr];
            end
            if (host_rd)
                rdata_q <= bus_io.host_sel == 2'd0 ? mem_a[addr] : bus_io.host_sel == 2'd1 ? mem_b[addr] : mem_c[addr];
            if (state_q == DRAIN && acc_q && !phase_q) c_rd_q <= mem_c[addr];
        end
    end
    always_ff @(posedge clk) begin
        if (cap) buf_q[ptr_q[RW-1:0]] <= bus_io.core_c_data;
    end
    // writes are gated by resetn so a reset mid-DRAIN stops at the current row
    always_ff @(posedge clk) begin
        if (resetn && host_wr && bus_io.host_sel == 2'd0) mem_a[addr] <= bus_io.host_wdata;
        if (resetn && host_wr && bus_io.host_sel == 2'd1) mem_b[addr] <= bus_io.host_wdata;
        if (resetn && (drain_wr || (host_wr && bus_io.host_sel == 2'd2))) mem_c[addr] <= c_wdata;
    end
    assign bus_io.host_rdata   = rdata_q;
    assign bus_io.host_rvalid  = rvalid_q;
    assign bus_io.busy         = busy;
    assign bus_io.done         = done_q;
    assign bus_io.err          = err_q;
    assign bus_io.core_start   = start_q;
    assign bus_io.core_a_valid = a_valid_q;
    assign bus_io.core_a_data  = a_q;
    assign bus_io.core_b_data  = b_q;
endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb_matmul_tile_sequencer: directed runs with a queue scoreboard for reads, streams, done and err pulses
module tb_matmul_tile_sequencer;
    localparam int DW = 8;
    localparam int N  = 8;
    localparam int AW = 7;
    localparam int W  = N * DW;
    localparam int D  = 2 ** AW;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           cy;
        logic         st;
    } ab_t;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] a_m [D];
    logic [7:0] b_m [D];
    logic [7:0] c_m [D];
    ab_t exp_ab [$];
    logic [W-1:0] exp_rd [$];
    int exp_done [$];
    int exp_err [$];
    matmul_tile_sequencer_if #(.DWIDTH(DW), .N(N), .AWIDTH(AW)) bus ();
    matmul_tile_sequencer #(.DWIDTH(DW), .N(N), .AWIDTH(AW)) dut (.clk(clk), .resetn(resetn), .bus_io(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [W-1:0] rep(input logic [7:0] v);
        return {N{v}};
    endfunction
    function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction
    function automatic void unexp(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got an unexpected pulse at cycle %0d, expected none", nm, cyc);
    endfunction
    always @(negedge clk) begin : monitor
        ab_t e;
        if (bus.host_rvalid) begin
            if (exp_rd.size() == 0) unexp("host_rvalid");
            else chk("host_rdata", bus.host_rdata, exp_rd.pop_front());
        end
        if (bus.core_a_valid) begin
            if (exp_ab.size() == 0) unexp("core_a_valid");
            else begin
                e = exp_ab.pop_front();
                chk("core_a_data", bus.core_a_data, e.a);
                chk("core_b_data", bus.core_b_data, e.b);
                chk("core_a_valid_cycle", W'(cyc), W'(e.cy));
                chk("core_start", W'(bus.core_start), W'(e.st));
            end
        end else if (bus.core_start) unexp("core_start");
        if (bus.done) begin
            if (exp_done.size() == 0) unexp("done");
            else chk("done_cycle", W'(cyc), W'(exp_done.pop_front()));
        end
        if (bus.err) begin
            if (exp_err.size() == 0) unexp("err");
            else chk("err_cycle", W'(cyc), W'(exp_err.pop_front()));
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic host_wr(input logic [1:0] sel, input int addr, input logic [7:0] v);
        bus.host_we = 1'b1;
        bus.host_sel = sel;
        bus.host_addr = AW'(addr);
        bus.host_wdata = rep(v);
        if (sel == 2'd0) a_m[addr] = v;
        else if (sel == 2'd1) b_m[addr] = v;
        else if (sel == 2'd2) c_m[addr] = v;
        tick;
        bus.host_we = 1'b0;
    endtask
    task automatic host_rd(input logic [1:0] sel, input int addr);
        bus.host_re = 1'b1;
        bus.host_sel = sel;
        bus.host_addr = AW'(addr);
        exp_rd.push_back(rep(sel == 2'd0 ? a_m[addr] : sel == 2'd1 ? b_m[addr] : c_m[addr]));
        tick;
        bus.host_re = 1'b0;
    endtask
    task automatic wait_idle;
        int n = 0;
        while (bus.busy && n < 64) begin
            tick;
            n++;
        end
        chk("busy_after_run", W'(bus.busy), '0);
    endtask
    task automatic verify(input int base);
        for (int j = 0; j < N; j++) host_rd(2'd2, (base + j) % D);
        host_rd(2'd0, base);
    endtask
    task automatic run_tile(input int base, input logic acc, input logic [7:0] r0, input logic inc, input logic cut);
        int c0;
        int t;
        ab_t e;
        logic [7:0] res [N];
        c0 = cyc;
        for (int i = 0; i < N; i++) begin
            e.a = rep(a_m[(base + i) % D]);
            e.b = rep(b_m[(base + i) % D]);
            e.cy = c0 + i + 2;
            e.st = i == 0;
            exp_ab.push_back(e);
        end
        bus.start = 1'b1;
        bus.tile_base = AW'(base);
        bus.accumulate = acc;
        tick;
        bus.host_we = 1'b1;
        bus.host_sel = 2'd0;
        bus.host_addr = AW'(base);
        bus.host_wdata = rep(8'hEE);
        exp_err.push_back(c0 + 2);
        tick;
        bus.start = 1'b0;
        bus.host_we = 1'b0;
        for (int j = 0; j < N; j++) begin
            res[j] = r0 + (inc ? 8'(j) : 8'd0);
            bus.core_c_valid = 1'b1;
            bus.core_c_data = rep(res[j]);
            tick;
        end
        t = c0 + N + 1;
        bus.core_c_data = rep(8'h55);
        tick;
        bus.core_c_valid = 1'b0;
        if (cut) begin
            tick;
            tick;
            resetn = 1'b0;
            tick;
            chk("busy_after_cut", W'(bus.busy), '0);
            chk("done_after_cut", W'(bus.done), '0);
            resetn = 1'b1;
            for (int j = 0; j < 3; j++) c_m[(base + j) % D] = res[j];
        end else begin
            exp_done.push_back(t + (acc ? 2 * N : N) + 1);
            for (int j = 0; j < N; j++) c_m[(base + j) % D] = acc ? c_m[(base + j) % D] + res[j] : res[j];
            wait_idle;
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end
    initial begin
        bus.host_we = 1'b0;
        bus.host_re = 1'b0;
        bus.host_sel = 2'd0;
        bus.host_addr = '0;
        bus.host_wdata = '0;
        bus.start = 1'b0;
        bus.tile_base = '0;
        bus.accumulate = 1'b0;
        bus.core_c_valid = 1'b0;
        bus.core_c_data = '0;
        repeat (3) tick;
        chk("rst_busy", W'(bus.busy), '0);
        chk("rst_done", W'(bus.done), '0);
        chk("rst_err", W'(bus.err), '0);
        chk("rst_core_start", W'(bus.core_start), '0);
        chk("rst_core_a_valid", W'(bus.core_a_valid), '0);
        chk("rst_host_rvalid", W'(bus.host_rvalid), '0);
        chk("rst_core_a_data", bus.core_a_data, '0);
        chk("rst_host_rdata", bus.host_rdata, '0);
        resetn = 1'b1;
        for (int r = 0; r < N; r++) begin
            host_wr(2'd0, r, 8'(r + 1));
            host_wr(2'd1, r, 8'(8'h10 + r));
        end
        for (int k = 0; k < 4; k++) begin
            host_wr(2'd0, 124 + k, 8'(8'h30 + k));
            host_wr(2'd1, 124 + k, 8'(8'h40 + k));
        end
        host_rd(2'd0, 0);
        host_rd(2'd1, 7);
        host_rd(2'd0, 126);
        bus.host_we = 1'b1;
        bus.host_re = 1'b1;
        bus.host_sel = 2'd0;
        bus.host_addr = AW'(1);
        bus.host_wdata = rep(8'h77);
        exp_err.push_back(cyc + 1);
        tick;
        bus.host_we = 1'b0;
        bus.host_sel = 2'd3;
        exp_err.push_back(cyc + 1);
        tick;
        bus.host_re = 1'b0;
        bus.host_we = 1'b1;
        exp_err.push_back(cyc + 1);
        tick;
        bus.host_we = 1'b0;
        host_rd(2'd0, 1);
        resetn = 1'b0;
        repeat (3) tick;
        resetn = 1'b1;
        chk("busy_after_reset", W'(bus.busy), '0);
        host_rd(2'd0, 0);
        run_tile(0, 1'b0, 8'hA0, 1'b1, 1'b0);
        verify(0);
        for (int j = 0; j < N; j++) host_wr(2'd2, j, 8'hFF);
        run_tile(0, 1'b1, 8'h02, 1'b0, 1'b0);
        verify(0);
        run_tile(124, 1'b0, 8'hC0, 1'b1, 1'b0);
        verify(124);
        host_rd(2'd2, 4);
        run_tile(0, 1'b0, 8'hD0, 1'b1, 1'b1);
        verify(0);
        repeat (3) tick;
        chk("rd_left", W'(exp_rd.size()), '0);
        chk("stream_left", W'(exp_ab.size()), '0);
        chk("done_left", W'(exp_done.size()), '0);
        chk("err_left", W'(exp_err.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
